vga_grid_scanout: RTL and testbench

//   Display stage on the second port of the Tron dual-port memory (exemem port 2).

---
 rtl/vga_grid_scanout.sv | 106 ++++++++++
 tb/tb_vga_grid_scanout.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vga_grid_scanout.sv
// 640x480@60 VGA scan-out that reads one 16-bit grid word per 8x8 cell from a
// read-only memory port and drives registered sync, blanking and 8-bit colour.
module vga_grid_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned CELL_SHIFT = 3,
    parameter logic [15:0] GRID_BASE  = 16'hC000,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_data,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  rgb,
    output logic        vblank,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned GRID_W  = H_ACTIVE >> CELL_SHIFT;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = $clog2(CLK_DIV);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;
    logic          pix_en;
    logic          h_wrap;
    logic          v_wrap;
    logic          active;
    logic [15:0]   cell_row_off;
    logic [15:0]   cell_col;
    logic [7:0]    unused_mem_hi;

    assign pix_en = (div_q == DIV_LAST);
    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);
    assign active = (h_q < H_ACT_END) && (v_q < V_ACT_END);

    // Counters only move on pix_en, so the address holds for the whole pixel period.
    assign cell_row_off = 16'(32'(v_q >> CELL_SHIFT) * GRID_W);
    assign cell_col     = 16'(h_q >> CELL_SHIFT);
    assign mem_addr     = active ? (GRID_BASE + cell_row_off + cell_col) : GRID_BASE;

    assign mem_din       = 16'h0000;
    assign mem_we        = 1'b0;
    assign unused_mem_hi = mem_data[15:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= pix_en ? '0 : div_q + DW'(1);
            if (pix_en) begin
                h_q <= h_wrap ? '0 : h_q + HW'(1);
                if (h_wrap) begin
                    v_q <= v_wrap ? '0 : v_q + VW'(1);
                end
            end
        end
    end

    // Outputs describe the pixel whose period is ending; mem_data is valid on pix_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= 8'h00;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                hsync  <= !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
                vsync  <= !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
                vblank <= (v_q >= V_ACT_END);
                rgb    <= active ? mem_data[7:0] : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_vga_grid_scanout.sv
// Scoreboard bench: a full-size instance and a shrunken CLK_DIV=4 instance share one
// randomly filled memory; expected pixels are derived from frame arithmetic.
module tb_vga_grid_scanout;

    logic clk = 1'b0;
    logic reset;
    logic armed = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];

    // Instance 0: default timing. Instance 1: 80x22 frame, CLK_DIV=4.
    int ha [2] = '{640, 64};
    int hf [2] = '{16, 4};
    int hs [2] = '{96, 8};
    int hb [2] = '{48, 4};
    int va [2] = '{480, 16};
    int vf [2] = '{10, 2};
    int vs [2] = '{2, 2};
    int vbp[2] = '{33, 2};
    int dv [2] = '{2, 4};

    logic [15:0] md0, ma0, din0, md1, ma1, din1;
    logic        we0, hs0, vs0, vb0, fs0, we1, hs1, vs1, vb1, fs1;
    logic [7:0]  rgb0, rgb1;

    vga_grid_scanout u_full (
        .clk(clk), .reset(reset), .mem_data(md0), .mem_addr(ma0), .mem_din(din0),
        .mem_we(we0), .hsync(hs0), .vsync(vs0), .rgb(rgb0), .vblank(vb0),
        .frame_start(fs0)
    );

    vga_grid_scanout #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .CELL_SHIFT(3), .GRID_BASE(16'hC000), .CLK_DIV(4)
    ) u_small (
        .clk(clk), .reset(reset), .mem_data(md1), .mem_addr(ma1), .mem_din(din1),
        .mem_we(we1), .hsync(hs1), .vsync(vs1), .rgb(rgb1), .vblank(vb1),
        .frame_start(fs1)
    );

    // 1-clk synchronous-read memory port for each instance
    always @(posedge clk) begin
        md0 <= mem[ma0];
        md1 <= mem[ma1];
    end

    int vectors = 0;
    int fails   = 0;

    // Packed expectation: {hsync, vsync, vblank, frame_start, rgb[7:0]}
    localparam logic [11:0] RST_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [11:0] cur0 = RST_OUT;
    logic [11:0] cur1 = RST_OUT;
    logic [15:0] exp_addr [2] = '{16'hC000, 16'hC000};
    int n = 0;

    function automatic logic [15:0] addr_of(input int i, input int h, input int v);
        if (h < ha[i] && v < va[i])
            return 16'(32'hC000 + (v / 8) * (ha[i] / 8) + (h / 8));
        return 16'hC000;
    endfunction

    function automatic logic [11:0] exp_pix(input int i, input int q);
        int ht, vt, h, v;
        logic e_hs, e_vs, e_vb, e_fs;
        logic [7:0] e_rgb;
        logic [15:0] w;
        ht = ha[i] + hf[i] + hs[i] + hb[i];
        vt = va[i] + vf[i] + vs[i] + vbp[i];
        h = q % ht;
        v = (q / ht) % vt;
        e_hs = !(h >= ha[i] + hf[i] && h < ha[i] + hf[i] + hs[i]);
        e_vs = !(v >= va[i] + vf[i] && v < va[i] + vf[i] + vs[i]);
        e_vb = (v >= va[i]);
        e_fs = ((q + 1) % (ht * vt)) == 0;
        w = mem[addr_of(i, h, v)];
        e_rgb = (h < ha[i] && v < va[i]) ? w[7:0] : 8'h00;
        return {e_hs, e_vs, e_vb, e_fs, e_rgb};
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d t=%0t got %h expected %h", name, i, $time, act, exp);
        end
    endtask

    // Reference model: each completed pixel period issues one expected output word.
    always @(posedge clk or posedge reset) begin
        if (armed) begin
            if (reset) begin
                n = 0;
                for (int i = 0; i < 2; i++) exp_addr[i] = addr_of(i, 0, 0);
            end else begin
                n++;
                for (int i = 0; i < 2; i++) begin
                    int p, ht, vt;
                    ht = ha[i] + hf[i] + hs[i] + hb[i];
                    vt = va[i] + vf[i] + vs[i] + vbp[i];
                    p = n / dv[i];
                    if (n % dv[i] == 0) begin
                        if (i == 0) q0.push_back(exp_pix(i, p - 1));
                        else        q1.push_back(exp_pix(i, p - 1));
                    end
                    exp_addr[i] = addr_of(i, p % ht, (p / ht) % vt);
                end
            end
        end
    end

    // Monitor: pops new pixel outputs as they appear and checks holds in between.
    always @(negedge clk) begin
        if (armed) begin
            if (reset) begin
                cur0 = RST_OUT;
                cur1 = RST_OUT;
                q0.delete();
                q1.delete();
            end else begin
                if (q0.size() > 0) cur0 = q0.pop_front();
                if (q1.size() > 0) cur1 = q1.pop_front();
            end
            chk("outputs", 0, {20'h0, hs0, vs0, vb0, fs0, rgb0}, {20'h0, cur0});
            chk("outputs", 1, {20'h0, hs1, vs1, vb1, fs1, rgb1}, {20'h0, cur1});
            chk("mem_addr", 0, {16'h0, ma0}, {16'h0, exp_addr[0]});
            chk("mem_addr", 1, {16'h0, ma1}, {16'h0, exp_addr[1]});
            chk("mem_we_din", 0, {15'h0, we0, din0}, 32'h0);
            chk("mem_we_din", 1, {15'h0, we1, din1}, 32'h0);
            // frame_start is a single-clk pulse
            cur0[8] = 1'b0;
            cur1[8] = 1'b0;
        end
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        for (int a = 16'hC000; a < 16'hE000; a++) mem[a] = 16'($urandom);
        mem[16'hC000] = 16'hFFE0;
        mem[16'hC001] = 16'h001C;

        reset = 1'b0;
        #1;
        armed = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        repeat (40000) @(posedge clk);

        // Asynchronous mid-frame reset, away from any clock edge
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        chk("async_reset", 0, {20'h0, hs0, vs0, vb0, fs0, rgb0}, {20'h0, RST_OUT});
        chk("async_reset", 1, {20'h0, hs1, vs1, vb1, fs1, rgb1}, {20'h0, RST_OUT});
        chk("async_reset_addr", 0, {16'h0, ma0}, 32'h0000C000);
        chk("async_reset_addr", 1, {16'h0, ma1}, 32'h0000C000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;

        repeat (15000) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
